// File: rtl/adc_scanner_if.sv
// Wishbone slave port bundle for the ADC scanner.
// 16-bit data, single-cycle acknowledge.
interface adc_scanner_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [15:0] wb_adr_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i,
      output wb_adr_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i,
      input  wb_adr_i, wb_dat_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/adc_scanner.sv
// Sequences the ADC macro over the enabled channels and
// emits one result strobe per completed conversion.
module adc_scanner #(
   parameter logic [31:0] DEFAULT_MASK     = 32'hFFFF_FFFF,
   parameter logic [15:0] DEFAULT_INTERVAL = 16'd50,
   parameter logic [15:0] TIMEOUT          = 16'd1023
) (
   input  logic                clk,
   input  logic                reset,
   adc_scanner_if.slave        wb,
   input  logic                adc_calibrate,
   input  logic                adc_busy,
   input  logic                adc_datavalid,
   input  logic [11:0]         adc_data,
   output logic                adc_start,
   output logic [4:0]          adc_chnum,
   output logic                adc_strb,
   output logic [4:0]          adc_channel,
   output logic [11:0]         adc_result
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_START,
      S_CONVERT,
      S_OUTPUT,
      S_WAIT
   } state_t;

   state_t      r_state;
   logic [31:0] r_mask;
   logic [15:0] r_interval;
   logic        r_enable;
   logic [7:0]  r_tocount;
   logic        r_ack;
   logic [15:0] r_dat;
   logic        r_start;
   logic [4:0]  r_chnum;
   logic        r_strb;
   logic [4:0]  r_channel;
   logic [11:0] r_result;
   logic [11:0] r_capture;
   logic [4:0]  r_cand;
   logic [4:0]  r_last;
   logic [15:0] r_tcnt;
   logic [15:0] r_wcnt;

   logic        w_req;
   logic        w_wr;
   logic        w_rd;
   logic [2:0]  w_adr;
   logic [15:0] w_status;
   logic [15:0] w_rdata;
   logic        w_timeout;
   logic        w_unused_adr;

   // An access is accepted only when no ack is outstanding,
   // so a held strobe cannot produce back-to-back acks.
   assign w_req = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
   assign w_wr  = w_req & wb.wb_we_i;
   assign w_rd  = w_req & ~wb.wb_we_i;
   assign w_adr = wb.wb_adr_i[2:0];
   assign w_unused_adr = |wb.wb_adr_i[15:3];

   assign w_status = {r_tocount, adc_busy, 2'b00, r_last};

   assign w_timeout = (r_state == S_CONVERT)
                    && !adc_datavalid
                    && (r_tcnt == TIMEOUT - 16'd1);

   // Register read multiplexer.
   always_comb begin
      w_rdata = 16'd0;
      case (w_adr)
         3'd0:    w_rdata = r_mask[15:0];
         3'd1:    w_rdata = r_mask[31:16];
         3'd2:    w_rdata = r_interval;
         3'd3:    w_rdata = {15'd0, r_enable};
         3'd4:    w_rdata = w_status;
         3'd5:    w_rdata = w_status;
         default: w_rdata = 16'd0;
      endcase
   end

   // Wishbone slave: ack, read data and writable registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ack      <= 1'b0;
         r_dat      <= 16'd0;
         r_mask     <= DEFAULT_MASK;
         r_interval <= DEFAULT_INTERVAL;
         r_enable   <= 1'b1;
      end else begin
         r_ack <= w_req;
         r_dat <= w_rd ? w_rdata : 16'd0;
         if (w_wr) begin
            case (w_adr)
               3'd0:    r_mask[15:0]  <= wb.wb_dat_i;
               3'd1:    r_mask[31:16] <= wb.wb_dat_i;
               3'd2:    r_interval    <= wb.wb_dat_i;
               3'd3:    r_enable      <= wb.wb_dat_i[0];
               default: ;
            endcase
         end
      end
   end

   // Saturating timeout counter, cleared by a read of addr 5.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tocount <= 8'd0;
      end else if (w_rd && (w_adr == 3'd5)) begin
         r_tocount <= 8'd0;
      end else if (w_timeout && (r_tocount != 8'hFF)) begin
         r_tocount <= r_tocount + 8'd1;
      end
   end

   // Scan sequencer: channel select, start, convert, strobe, wait.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_start   <= 1'b0;
         r_chnum   <= 5'd0;
         r_strb    <= 1'b0;
         r_channel <= 5'd0;
         r_result  <= 12'd0;
         r_capture <= 12'd0;
         r_cand    <= 5'd0;
         r_last    <= 5'd0;
         r_tcnt    <= 16'd0;
         r_wcnt    <= 16'd0;
      end else begin
         r_start <= 1'b0;
         r_strb  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_enable && !adc_calibrate)
                  r_state <= S_SELECT;
            end
            S_SELECT: begin
               if (!r_enable) begin
                  r_state <= S_IDLE;
               end else if (r_mask[r_cand]) begin
                  r_chnum <= r_cand;
                  r_state <= S_START;
               end else begin
                  r_cand <= r_cand + 5'd1;
               end
            end
            S_START: begin
               r_start <= 1'b1;
               r_tcnt  <= 16'd0;
               r_state <= S_CONVERT;
            end
            S_CONVERT: begin
               if (adc_datavalid) begin
                  r_capture <= adc_data;
                  r_state   <= S_OUTPUT;
               end else if (w_timeout) begin
                  r_last  <= r_chnum;
                  r_cand  <= r_chnum + 5'd1;
                  r_wcnt  <= 16'd0;
                  r_state <= S_WAIT;
               end else begin
                  r_tcnt <= r_tcnt + 16'd1;
               end
            end
            S_OUTPUT: begin
               r_strb    <= 1'b1;
               r_channel <= r_chnum;
               r_result  <= r_capture;
               r_last    <= r_chnum;
               r_cand    <= r_chnum + 5'd1;
               r_wcnt    <= 16'd0;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wcnt == r_interval) begin
                  if (!r_enable || adc_calibrate)
                     r_state <= S_IDLE;
                  else
                     r_state <= S_SELECT;
               end else begin
                  r_wcnt <= r_wcnt + 16'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wb.wb_ack_o = r_ack;
   assign wb.wb_dat_o = r_dat;
   assign adc_start   = r_start;
   assign adc_chnum   = r_chnum;
   assign adc_strb    = r_strb;
   assign adc_channel = r_channel;
   assign adc_result  = r_result;

endmodule

// File: tb/tb_adc_scanner.sv
// Self-checking bench for adc_scanner with an ADC macro model
// and a channel-sequence reference model.
module tb_adc_scanner;

   logic        clk = 1'b0;
   logic        reset;
   logic        adc_calibrate;
   logic        adc_busy;
   logic        adc_datavalid;
   logic [11:0] adc_data;
   logic        adc_start;
   logic [4:0]  adc_chnum;
   logic        adc_strb;
   logic [4:0]  adc_channel;
   logic [11:0] adc_result;

   adc_scanner_if wb();

   adc_scanner dut (
      .clk           (clk),
      .reset         (reset),
      .wb            (wb),
      .adc_calibrate (adc_calibrate),
      .adc_busy      (adc_busy),
      .adc_datavalid (adc_datavalid),
      .adc_data      (adc_data),
      .adc_start     (adc_start),
      .adc_chnum     (adc_chnum),
      .adc_strb      (adc_strb),
      .adc_channel   (adc_channel),
      .adc_result    (adc_result)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          ncyc     = 0;
   int          lat      = 10;
   int          withhold = -1;
   logic [11:0] salt     = 12'd0;
   logic [31:0] mon_mask = 32'hFFFF_FFFF;
   int          cur_iv   = 50;
   int          gen      = 0;
   int          prev_st  = 31;
   int          n_start  = 0;
   int          n_strb   = 0;
   int          dv_cyc   = 0;
   int          stb_cyc  = 0;
   int          stb_ch   = 0;
   int          pend_gen = 0;
   bit          pend     = 0;
   int          m_cnt;
   logic [4:0]  m_ch;

   function automatic logic [11:0] f(input logic [4:0] ch);
      logic [11:0] v;
      v = {3'd0, ch, 4'd0};
      return v + salt;
   endfunction

   function automatic int next_en(input logic [31:0] m, input int prev);
      for (int k = 1; k <= 32; k++)
         if (m[(prev + k) % 32]) return (prev + k) % 32;
      return -1;
   endfunction

   // ADC macro model: result arrives lat cycles after a start.
   always @(posedge clk) begin
      adc_datavalid <= 1'b0;
      if (reset) begin
         m_cnt    <= 0;
         adc_busy <= 1'b0;
      end else if (adc_start) begin
         m_ch     <= adc_chnum;
         m_cnt    <= lat;
         adc_busy <= 1'b1;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            adc_busy <= 1'b0;
            if (int'(m_ch) != withhold) begin
               adc_datavalid <= 1'b1;
               adc_data      <= f(m_ch);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      int e;
      @(negedge clk);
      ncyc++;
      if (adc_datavalid) dv_cyc = ncyc;
      if (adc_start) begin
         n_start++;
         e = next_en(mon_mask, prev_st);
         chk("start_ch", 32'(adc_chnum), e);
         if (pend && pend_gen == gen)
            chk("strb_to_start", ncyc - stb_cyc,
                cur_iv + 3 + ((e - stb_ch - 1 + 32) % 32));
         pend    = 0;
         prev_st = int'(adc_chnum);
      end
      if (adc_strb) begin
         n_strb++;
         chk("strb_ch", 32'(adc_channel), prev_st);
         chk("strb_res", 32'(adc_result), 32'(f(5'(prev_st))));
         chk("dv_to_strb", ncyc - dv_cyc, 2);
         pend     = 1;
         stb_cyc  = ncyc;
         stb_ch   = prev_st;
         pend_gen = gen;
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [2:0] a,
                          input logic [15:0] d, input bit hold,
                          output logic [15:0] q);
      bit got;
      got = 0;
      q   = 16'd0;
      wb.wb_cyc_i = 1'b1;
      wb.wb_stb_i = 1'b1;
      wb.wb_we_i  = we;
      wb.wb_adr_i = {13'd0, a};
      wb.wb_dat_i = d;
      if (we) gen++;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (wb.wb_ack_o) begin
            got = 1;
            q   = wb.wb_dat_o;
            break;
         end
      end
      chk("wb_ack", 32'(got), 1);
      if (hold && got) begin
         tick();
         chk("wb_no_b2b_ack", 32'(wb.wb_ack_o), 0);
      end
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      wb.wb_we_i  = 1'b0;
   endtask

   task automatic wb_wr(input logic [2:0] a, input logic [15:0] d);
      logic [15:0] q;
      wb_xfer(1'b1, a, d, 1'b0, q);
      if (a == 3'd0) mon_mask[15:0]  = d;
      if (a == 3'd1) mon_mask[31:16] = d;
      if (a == 3'd2) cur_iv = int'(d);
   endtask

   task automatic wb_rd(input logic [2:0] a, output logic [15:0] q);
      wb_xfer(1'b0, a, 16'd0, 1'b0, q);
   endtask

   task automatic wait_strb(input int n, input int budget);
      int t;
      int k;
      t = n_strb + n;
      k = 0;
      while (n_strb < t && k < budget) begin
         tick();
         k++;
      end
      chk("strobe_wait", 32'(n_strb >= t), 1);
   endtask

   task automatic settle();
      wb_wr(3'd2 + 3'd1, 16'd0);
      repeat (1200) tick();
   endtask

   initial begin
      logic [15:0] q;
      logic [31:0] m;
      int          s0;
      int          b0;
      int          exp_to;
      int          k;

      reset         = 1'b1;
      adc_calibrate = 1'b1;
      wb.wb_cyc_i   = 1'b0;
      wb.wb_stb_i   = 1'b0;
      wb.wb_we_i    = 1'b0;
      wb.wb_adr_i   = 16'd0;
      wb.wb_dat_i   = 16'd0;

      repeat (3) tick();
      chk("rst_ack",     32'(wb.wb_ack_o), 0);
      chk("rst_dat",     32'(wb.wb_dat_o), 0);
      chk("rst_start",   32'(adc_start),   0);
      chk("rst_chnum",   32'(adc_chnum),   0);
      chk("rst_strb",    32'(adc_strb),    0);
      chk("rst_channel", 32'(adc_channel), 0);
      chk("rst_result",  32'(adc_result),  0);

      reset = 1'b0;
      repeat (100) tick();
      chk("no_start_calibrating", n_start, 0);
      adc_calibrate = 1'b0;

      // Full sweep 0..31 then 0 with default mask and interval.
      wait_strb(33, 4000);

      // Two-channel mask, interval 0.
      settle();
      wb_wr(3'd0, 16'h0005);
      wb_wr(3'd1, 16'h0000);
      wb_wr(3'd2, 16'd0);
      wb_wr(3'd3, 16'd1);
      wait_strb(4, 500);

      // Same mask, interval 100.
      settle();
      wb_wr(3'd2, 16'd100);
      wb_wr(3'd3, 16'd1);
      wait_strb(3, 1000);

      // Channel 3 never returns data.
      settle();
      wb_wr(3'd0, 16'h0018);
      wb_wr(3'd2, 16'd5);
      withhold = 3;
      exp_to = (next_en(mon_mask, prev_st) == 3) ? 1 : 0;
      wb_wr(3'd3, 16'd1);
      wait_strb(1, 3000);
      wb_wr(3'd3, 16'd0);
      repeat (200) tick();
      wb_rd(3'd4, q);
      chk("status_timeouts", 32'(q[15:8]), exp_to);
      chk("status_last",     32'(q[4:0]),  4);
      wb_rd(3'd5, q);
      wb_rd(3'd4, q);
      chk("status_cleared",  32'(q[15:8]), 0);
      withhold = -1;

      // Disable while a conversion is in flight.
      wb_wr(3'd0, 16'hFFFF);
      wb_wr(3'd1, 16'hFFFF);
      wb_wr(3'd2, 16'd10);
      lat = int'($urandom_range(5, 15));
      wb_wr(3'd3, 16'd1);
      s0 = n_start;
      k  = 0;
      while (n_start == s0 && k < 300) begin
         tick();
         k++;
      end
      chk("start_seen", 32'(n_start > s0), 1);
      s0 = n_start;
      b0 = n_strb;
      wb_wr(3'd3, 16'd0);
      repeat (300) tick();
      chk("inflight_strobed", n_strb - b0, 1);
      chk("no_start_disabled", n_start - s0, 0);
      wb_wr(3'd3, 16'd1);
      wait_strb(1, 300);

      // Randomized masks, intervals, latencies and results.
      for (int r = 0; r < 3; r++) begin
         settle();
         m = $urandom;
         if (m == 32'd0) m = 32'd1;
         salt = 12'($urandom);
         lat  = int'($urandom_range(1, 15));
         wb_wr(3'd0, m[15:0]);
         wb_wr(3'd1, m[31:16]);
         wb_wr(3'd2, 16'($urandom_range(0, 20)));
         wb_wr(3'd3, 16'd1);
         wait_strb(10, 3000);
      end

      // Register readback and idle scanner with empty mask.
      settle();
      wb_wr(3'd2, 16'hABCD);
      wb_xfer(1'b0, 3'd2, 16'd0, 1'b1, q);
      chk("interval_rb", 32'(q), 32'hABCD);
      wb_rd(3'd3, q);
      chk("enable_rb", 32'(q), 0);
      wb_wr(3'd6, 16'h1234);
      wb_rd(3'd6, q);
      chk("addr6_zero", 32'(q), 0);
      wb_wr(3'd0, 16'h0000);
      wb_wr(3'd1, 16'h0000);
      wb_rd(3'd1, q);
      chk("mask_hi_rb", 32'(q), 0);
      wb_wr(3'd3, 16'd1);
      s0 = n_start;
      repeat (5000) tick();
      chk("mask0_no_start", n_start - s0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
